fsm_div_arbiter: RTL
====================

FSM_DIV_ARBITER -- requirements
Module: fsm_div_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesters (2..4).
REQ-002 SHALL have parameter W, default 4: operand/result width, equal to the fsm_div data width.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles spent in WAIT before aborting.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ: per-requester job request.
REQ-007 SHALL have port req_ops, input, N_REQ*4*W: per-requester {d,c,b,a}, a in the least-significant bits.
REQ-008 SHALL have port req_ready, output, N_REQ: one-hot job acceptance.
REQ-009 SHALL have port rsp_valid, output, N_REQ: one-hot, 1-cycle result strobe.
REQ-010 SHALL have port rsp_data, output, W: result of a/b-c-d.
REQ-011 SHALL have port rsp_err, output, 2: 00 OK, 01 DIV_ZERO, 10 TIMEOUT.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port div_valid_in, output, 1: operand strobe to fsm_div.
REQ-014 SHALL have port div_d_in, output, W: operand to fsm_div.
REQ-015 SHALL have port div_reset, output, 1: active-high synchronous reset to fsm_div.
REQ-016 SHALL have port div_valid_out, input, 1: fsm_div result strobe.
REQ-017 SHALL have port div_d_out, input, W: fsm_div result.
REQ-018 SHALL have port div_error_out, input, 1: fsm_div division-by-zero flag.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, WAIT, RESP.
REQ-020 IDLE: if any req_valid, SHALL grant the first requester at or after rr_ptr (wrapping), assert req_ready[g] for that cycle only, latch g and its four operands, and go to SEND.
REQ-021 SHALL leave req_valid of non-granted requesters pending; req_ready SHALL be high only in the accepting IDLE cycle.
REQ-022 SEND: SHALL last exactly 8 cycles; in cycle 2k (k=0..3) div_valid_in=1 and div_d_in=operand k (a,b,c,d); in cycle 2k+1 div_valid_in=0 and div_d_in holds its value; then go to WAIT.
REQ-023 WAIT: SHALL clear the timer on entry; when div_valid_out=1, SHALL capture div_d_out and set rsp_err to div_error_out ? 01 : 00, then go to RESP.
REQ-024 WAIT: if the timer reaches TIMEOUT-1 without div_valid_out, SHALL set rsp_err=10 and rsp_data=0, pulse div_reset for 1 cycle, and go to RESP.
REQ-025 RESP: SHALL assert rsp_valid[g] for 1 cycle with rsp_data/rsp_err stable, set rr_ptr=(g+1) mod N_REQ, and go to IDLE.
REQ-026 Latency SHALL be: accept at T, SEND T+1..T+8, WAIT from T+9, rsp_valid in the cycle after div_valid_out is sampled high.
REQ-027 SHALL ignore div_valid_out outside WAIT.
REQ-028 SHALL allow a new grant in the IDLE cycle directly following RESP (no bubble beyond IDLE).
REQ-029 rsp_data and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-030 While reset=0, SHALL force: state IDLE, rr_ptr 0, timer 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 00, busy 0, div_valid_in 0, div_d_in 0.
REQ-031 div_reset SHALL be 1 while reset=0 and SHALL clear on the first clk edge after release.
REQ-032 Reset mid-job SHALL abort the job with no rsp_valid; the aborted requester re-arbitrates normally.

Structure
REQ-033 Package fsm_div_arb_pkg SHALL hold the state enum, rsp_err codes (ERR_OK, ERR_DIV_ZERO, ERR_TIMEOUT), and NUM_OPS=4.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, rr_ptr; output: one-hot grant).
REQ-035 fsm_div SHALL NOT be instantiated inside this block; the block connects to it through the div_* ports.

Verification
REQ-036 Bench SHALL drive req0 = (a=8,b=2,c=5,d=2) -> rsp_valid[0]=1, rsp_data=4'hD (-3), rsp_err=00, with the 8-cycle SEND pattern checked.
REQ-037 Bench SHALL drive req1 = (5,0,1,2) -> rsp_valid[1]=1, rsp_err=01.
REQ-038 Bench SHALL assert req0 and req1 together after reset -> req0 served first, then req1; repeating both -> req0 first again.
REQ-039 Bench SHALL use a fsm_div model that never asserts valid_out -> rsp_err=10 exactly TIMEOUT cycles after WAIT entry, div_reset high for 1 cycle.
REQ-040 Bench SHALL assert reset during SEND cycle 3 -> all outputs 0, div_reset=1, no rsp_valid; after release the pending request completes correctly.
REQ-041 Bench SHALL pulse div_valid_out in IDLE -> no rsp_valid and no state change.

Source files
------------

// File: rtl/fsm_div_arb_pkg.sv
// rtl/fsm_div_arb_pkg.sv - shared states, error codes and operand count for the divider arbiter
package fsm_div_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_DIV_ZERO = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam int NUM_OPS = 4;

endpackage

// File: rtl/fsm_div_arbiter_rr_pick.sv
// rtl/fsm_div_arbiter_rr_pick.sv - round-robin pick of the first request at or after ptr
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_div_arbiter.sv
// rtl/fsm_div_arbiter.sv - arbitrates requesters onto one external serial divider
module fsm_div_arbiter
  import fsm_div_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*NUM_OPS*W-1:0]   req_ops,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [W-1:0]                 rsp_data,
  output logic [1:0]                   rsp_err,
  output logic                         busy,
  output logic                         div_valid_in,
  output logic [W-1:0]                 div_d_in,
  output logic                         div_reset,
  input  logic                         div_valid_out,
  input  logic [W-1:0]                 div_d_out,
  input  logic                         div_error_out
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam int OPW = NUM_OPS * W;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, g_idx, pick_idx;
  logic [N_REQ-1:0] pick, g_oh;
  logic [OPW-1:0]   ops_q, pick_ops;
  logic [2:0]       send_cnt;
  logic [TW-1:0]    timer;
  logic             timeout_hit;

  rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  always_comb begin
    pick_idx = '0;
    pick_ops = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (pick[r]) begin
        pick_idx = PW'(r);
        pick_ops = req_ops[r*OPW +: OPW];
      end
    end
  end

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    rsp_valid    = '0;
    div_valid_in = 1'b0;
    div_d_in     = '0;
    case (state)
      S_IDLE: begin
        // reset gating keeps the combinational grant quiet while held in reset
        if (|req_valid) begin
          state_nxt = S_SEND;
          req_ready = reset ? pick : '0;
        end
      end
      S_SEND: begin
        div_valid_in = ~send_cnt[0];
        for (int k = 0; k < NUM_OPS; k++) begin
          if (send_cnt[2:1] == 2'(k)) div_d_in = ops_q[k*W +: W];
        end
        if (send_cnt == 3'd7) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (div_valid_out || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = g_oh;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      timer     <= '0;
      send_cnt  <= '0;
      ops_q     <= '0;
      g_idx     <= '0;
      g_oh      <= '0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      div_reset <= 1'b1;
    end else begin
      div_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            g_idx    <= pick_idx;
            g_oh     <= pick;
            ops_q    <= pick_ops;
            send_cnt <= '0;
          end
        end
        S_SEND: begin
          send_cnt <= send_cnt + 3'd1;
          timer    <= '0;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (div_valid_out) begin
            rsp_data <= div_d_out;
            rsp_err  <= div_error_out ? ERR_DIV_ZERO : ERR_OK;
          end else if (timeout_hit) begin
            // a hung divider is flushed so the next job starts from a clean operand count
            rsp_data  <= '0;
            rsp_err   <= ERR_TIMEOUT;
            div_reset <= 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr <= (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
